// File: rtl/aip_pkg.sv
// Shared types and constants for the AIP job sequencer: FSM state encoding,
// AIP bus widths and the default interrupt-clear write.
package aip_pkg;

    localparam int CONF_W = 5;
    localparam int DATA_W = 32;

    localparam logic [CONF_W-1:0] DEF_CFG_STATUS  = 5'h1E;
    localparam logic [DATA_W-1:0] DEF_INT_CLR_VAL = 32'h0000_0001;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_START,
        ST_WAIT_INT,
        ST_CLR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_HOLD,
        ST_FIN
    } seq_state_e;

endpackage

// File: rtl/aip_rd_slot.sv
// Read-return slot: counts the AIP read latency, captures aip_rdata and holds
// it with rd_valid until the host takes it.
module aip_rd_slot
    import aip_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wait_en_i,
    input  logic              ack_i,
    input  logic [DATA_W-1:0] aip_rdata_i,
    output logic              cap_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // The counter restarts every time the FSM enters the wait state.
    assign cap_o = wait_en_i && (lat_cnt_q == CNT_W'(RD_LAT - 1));

    always_comb begin
        lat_cnt_d  = wait_en_i ? lat_cnt_q + 1'b1 : '0;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (cap_o) begin
            rd_valid_d = 1'b1;
            rd_data_d  = aip_rdata_i;
        end else if (ack_i) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            lat_cnt_q  <= lat_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/aip_job_sequencer.sv
// Drives one AIP net port through write/start/wait-int/clear/read jobs.
// Optional WAIT_INT watchdog enabled by defining AIP_SEQ_TIMEOUT_EN.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1.
module aip_job_sequencer
    import aip_pkg::*;
#(
    parameter int                LEN_W       = 8,
    parameter int                RD_LAT      = 1,
    parameter logic [CONF_W-1:0] CFG_STATUS  = DEF_CFG_STATUS,
    parameter logic [DATA_W-1:0] INT_CLR_VAL = DEF_INT_CLR_VAL,
    parameter logic [15:0]       TIMEOUT_CYC = 16'hFFFF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [CONF_W-1:0] job_wr_cfg,
    input  logic [LEN_W-1:0]  job_wr_len,
    input  logic [CONF_W-1:0] job_rd_cfg,
    input  logic [LEN_W-1:0]  job_rd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CONF_W-1:0] aip_conf,
    output logic              aip_write,
    output logic              aip_read,
    output logic              aip_start,
    output logic [DATA_W-1:0] aip_wdata,
    input  logic [DATA_W-1:0] aip_rdata,
    input  logic              aip_int,
    output seq_state_e        dbg_state
);

    seq_state_e        state_q, state_d;
    logic [CONF_W-1:0] wr_cfg_q, wr_cfg_d, rd_cfg_q, rd_cfg_d;
    logic [LEN_W-1:0]  wr_len_q, wr_len_d, rd_len_q, rd_len_d;
    logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [CONF_W-1:0] aip_conf_q, aip_conf_d;
    logic [DATA_W-1:0] aip_wdata_q, aip_wdata_d;
    logic              aip_write_q, aip_write_d;
    logic              aip_read_q, aip_read_d;
    logic              aip_start_q, aip_start_d;
    logic              rd_cap;
    logic              timeout_hit;
    logic              timed_out;

`ifdef AIP_SEQ_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        to_flag_q, to_flag_d;

    assign timeout_hit = (state_q == ST_WAIT_INT) && (to_cnt_q == TIMEOUT_CYC - 16'd1);
    assign timed_out   = to_flag_q;

    // An interrupt arriving in the expiry cycle wins over the watchdog.
    always_comb begin
        to_cnt_d  = (state_q == ST_WAIT_INT) ? to_cnt_q + 16'd1 : 16'd0;
        to_flag_d = to_flag_q;
        if (state_q == ST_IDLE) begin
            to_flag_d = 1'b0;
        end else if (timeout_hit && !aip_int) begin
            to_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt_q  <= 16'd0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
    assign timed_out          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_cfg_d    = wr_cfg_q;
        rd_cfg_d    = rd_cfg_q;
        wr_len_d    = wr_len_q;
        rd_len_d    = rd_len_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        aip_conf_d  = aip_conf_q;
        aip_wdata_d = aip_wdata_q;
        aip_write_d = 1'b0;
        aip_read_d  = 1'b0;
        aip_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    wr_cfg_d = job_wr_cfg;
                    rd_cfg_d = job_rd_cfg;
                    wr_len_d = job_wr_len;
                    rd_len_d = job_rd_len;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                    if (job_wr_len != '0) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d     = ST_START;
                        aip_start_d = 1'b1;
                    end
                end
            end
            ST_WR_DATA: begin
                if (wr_valid) begin
                    aip_write_d = 1'b1;
                    aip_conf_d  = wr_cfg_q;
                    aip_wdata_d = wr_data;
                    wr_cnt_d    = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == wr_len_q - 1'b1) begin
                        state_d     = ST_START;
                        aip_start_d = 1'b1;
                    end
                end
            end
            ST_START: state_d = ST_WAIT_INT;
            ST_WAIT_INT: begin
                if (aip_int || timeout_hit) begin
                    state_d     = ST_CLR;
                    aip_write_d = 1'b1;
                    aip_conf_d  = CFG_STATUS;
                    aip_wdata_d = INT_CLR_VAL;
                end
            end
            ST_CLR: begin
                if ((rd_len_q != '0) && !timed_out) begin
                    state_d    = ST_RD_ISSUE;
                    aip_read_d = 1'b1;
                    aip_conf_d = rd_cfg_q;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (rd_cap) state_d = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                if (rd_ready) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == rd_len_q - 1'b1) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d    = ST_RD_ISSUE;
                        aip_read_d = 1'b1;
                        aip_conf_d = rd_cfg_q;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            wr_cfg_q    <= '0;
            rd_cfg_q    <= '0;
            wr_len_q    <= '0;
            rd_len_q    <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            aip_conf_q  <= '0;
            aip_wdata_q <= '0;
            aip_write_q <= 1'b0;
            aip_read_q  <= 1'b0;
            aip_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cfg_q    <= wr_cfg_d;
            rd_cfg_q    <= rd_cfg_d;
            wr_len_q    <= wr_len_d;
            rd_len_q    <= rd_len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            aip_conf_q  <= aip_conf_d;
            aip_wdata_q <= aip_wdata_d;
            aip_write_q <= aip_write_d;
            aip_read_q  <= aip_read_d;
            aip_start_q <= aip_start_d;
        end
    end

    aip_rd_slot #(.RD_LAT(RD_LAT)) u_rd_slot (
        .clk        (clk),
        .resetn     (resetn),
        .wait_en_i  (state_q == ST_RD_WAIT),
        .ack_i      (rd_valid && rd_ready),
        .aip_rdata_i(aip_rdata),
        .cap_o      (rd_cap),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data)
    );

    // job_ready is gated by resetn so it stays low while reset is held.
    assign job_ready = resetn && (state_q == ST_IDLE);
    assign wr_ready  = (state_q == ST_WR_DATA);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done      = (state_q == ST_FIN);
    assign err       = (state_q == ST_FIN) && timed_out;
    assign aip_conf  = aip_conf_q;
    assign aip_write = aip_write_q;
    assign aip_read  = aip_read_q;
    assign aip_start = aip_start_q;
    assign aip_wdata = aip_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: doc/aip_job_sequencer.md
Name: aip_job_sequencer

Overview:
Host-side controller that drives one AIP coprocessor net port (conf_dbus/read/write/start/data_in/data_out/int_req) through a complete job:
- write a block of input words,
- pulse start,
- wait for the interrupt, then clear it by a status write,
- read back a block of result words.

It sits between a host master (DMA, NoC bridge or CPU peripheral) and the AIP net port. It serialises jobs so that only one job owns the port at a time.

Parameters:
LEN_W, 8, width of word-count fields (max 2^LEN_W-1 words per phase)
RD_LAT, 1, cycles from aip_read assertion to valid aip_data_in (>=1)
CFG_STATUS, 5'h1E, conf_dbus code used for the interrupt-clear write
INT_CLR_VAL, 32'h0000_0001, data written to CFG_STATUS to clear the interrupt
TIMEOUT_CYC, 16'hFFFF, WAIT_INT watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
job_valid  in  1  job descriptor valid
job_ready  out  1  descriptor accepted when job_valid&job_ready
job_wr_cfg  in  5  conf_dbus code for the input-data writes
job_wr_len  in  LEN_W  number of input words
job_rd_cfg  in  5  conf_dbus code for the result reads
job_rd_len  in  LEN_W  number of result words
wr_valid  in  1  input word valid
wr_ready  out  1  input word consumed
wr_data  in  32  input word
rd_valid  out  1  result word valid
rd_ready  in  1  result word consumed
rd_data  out  32  result word
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
err  out  1  one-cycle pulse with done on timeout
aip_conf  out  5  to AIP conf_dbus
aip_write  out  1  to AIP write
aip_read  out  1  to AIP read
aip_start  out  1  to AIP start
aip_wdata  out  32  to AIP data_in
aip_rdata  in  32  from AIP data_out
aip_int  in  1  from AIP int_req (level)

Behaviour:
- Reset is asynchronous, active-low; only clk and resetn are used. While resetn=0 every output is 0 and the FSM is in IDLE, except job_ready, which is 1 once resetn=1. All AIP outputs are registered.
- A reset mid-job aborts immediately. No done is generated and the AIP is not cleaned up; the host must reset or reconfigure the AIP.
- FSM states: IDLE, WR_DATA, START, WAIT_INT, CLR, RD_ISSUE, RD_WAIT, RD_HOLD, FIN.
- IDLE:
  - job_ready=1.
  - On handshake, latch the cfg/len fields and set busy=1.
  - Next state is WR_DATA if wr_len!=0, else START.
  - job_valid in any other state is ignored (job_ready=0).
- WR_DATA:
  - wr_ready=1. Each wr_valid&wr_ready produces aip_write=1, aip_conf=wr_cfg, aip_wdata=wr_data in the next cycle.
  - Back-to-back writes give 1 word/cycle; gaps in wr_valid give aip_write=0 in the gap cycles.
  - After wr_len accepted words, go to START.
- START: aip_start=1 for exactly one cycle, then WAIT_INT.
- WAIT_INT:
  - aip_int is sampled from the cycle after the start pulse.
  - When aip_int=1, go to CLR.
- CLR:
  - One cycle with aip_write=1, aip_conf=CFG_STATUS, aip_wdata=INT_CLR_VAL.
  - Then go to RD_ISSUE if rd_len!=0, else FIN.
- RD_ISSUE: one cycle with aip_read=1, aip_conf=rd_cfg, then RD_WAIT.
- RD_WAIT: wait RD_LAT cycles, then capture aip_rdata into rd_data, set rd_valid=1, go to RD_HOLD.
- RD_HOLD:
  - rd_valid and rd_data are held stable until rd_ready.
  - On handshake rd_valid=0; if words remain go to RD_ISSUE, else FIN.
  - Throughput is 1 word per RD_LAT+2 cycles when rd_ready is held high.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- aip_conf holds its last driven value between strobes. It is 0 after reset.
- Word counters are LEN_W bits, count up to len, and never wrap; len=0 skips its phase entirely.
- Without the optional feature, WAIT_INT can wait indefinitely.

Optional Feature:
Macro AIP_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_INT and increments each cycle there.
  - When it reaches TIMEOUT_CYC with aip_int still 0, go to CLR (clear write still issued), then skip the read phase.
  - FIN then asserts done=1 and err=1 in the same cycle.
  - aip_int=1 on the same cycle as expiry counts as success.
- Not defined: no counter, err is tied to 0.

Decomposition:
- Shared package aip_pkg: FSM state enum, conf_dbus width constant (5), data width constant (32), default CFG_STATUS and INT_CLR_VAL.
- Natural sub-module: aip_rd_slot, the RD_WAIT latency counter plus the rd_data/rd_valid holding register. Everything else stays flat.

Test Plan:
1. Basic job. Stimulus: job wr_cfg=5'h2, wr_len=4, wr_data 0x11..0x44 back-to-back; rd_cfg=5'h3, rd_len=2; model drives aip_int 10 cycles after start and rd_data 0xA0, 0xA1. Response: 4 consecutive aip_write cycles with conf 2; single aip_start; CLR write of 0x1 to 5'h1E; 2 aip_read pulses; rd_data 0xA0 then 0xA1; one done pulse; err=0.
2. Backpressure. Stimulus: wr_valid toggling 1/0; rd_ready held 0 for 5 cycles. Response: aip_write only on accepted words; rd_data stable during the hold; no extra aip_read issued.
3. Zero lengths. Stimulus: wr_len=0, rd_len=0. Response: START in the cycle after acceptance; CLR after int; done; no aip_read and no data aip_write.
4. Job overlap. Stimulus: job_valid held high throughout a job. Response: job_ready=0 while busy; second job accepted in the IDLE cycle after done.
5. Reset mid-job. Stimulus: resetn low during WAIT_INT. Response: all AIP outputs 0 immediately; no done; job_ready=1 after release.
6. Timeout. Stimulus: build with AIP_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, rd_len=3, aip_int held 0. Response: CLR write occurs 16 cycles after entry to WAIT_INT; no aip_read; done=err=1 in the same cycle.
